waveform_uart_framer: RTL and testbench

Downstream consumer of the 32-sample capture stage. Detects a capture trigger, waits until the capture array is fully written, snapshots all samples, and streams them as a framed byte sequence to the UART transmitter over a valid/ready byte handshake. Sits between the waveform capture stage and the UART TX.

---
 rtl/waveform_pkg.sv | 54 +++++
 rtl/waveform_uart_framer_tx_byte_stage.sv | 44 ++++
 rtl/waveform_uart_framer.sv | 128 ++++++++++++
 tb/tb_waveform_uart_framer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_pkg.sv
// rtl/waveform_pkg.sv - shared constants, types and frame byte helpers for the waveform UART framer
package waveform_pkg;

    localparam int N_SAMPLES     = 32;
    localparam int SAMPLE_W      = 14;
    localparam int SETTLE_CYCLES = 33;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int FRAME_BYTES = 2 + 2 * N_SAMPLES + 1;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam int SIDX_W      = $clog2(N_SAMPLES);
    localparam int CNT_W       = $clog2(SETTLE_CYCLES);

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef sample_t [N_SAMPLES-1:0] waveform_t;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SEND
    } framer_state_t;

    // XOR of the sequence byte and every sample byte; the sync byte is not covered.
    function automatic logic [7:0] frame_checksum(input logic [7:0] seq, input waveform_t w);
        logic [15:0] ext;
        frame_checksum = seq;
        for (int i = 0; i < N_SAMPLES; i++) begin
            ext = 16'(w[i]);
            frame_checksum = frame_checksum ^ ext[15:8] ^ ext[7:0];
        end
    endfunction

    // Byte at position idx of a frame: sync, sequence, hi/lo per sample, checksum.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [7:0] seq,
                                              input waveform_t w);
        logic [IDX_W-1:0]  off;
        logic [SIDX_W-1:0] sidx;
        logic [15:0]       ext;
        off  = idx - IDX_W'(2);
        sidx = SIDX_W'(off >> 1);
        ext  = 16'(w[sidx]);
        if (idx == IDX_W'(0)) begin
            frame_byte = SYNC_BYTE;
        end else if (idx == IDX_W'(1)) begin
            frame_byte = seq;
        end else if (idx == IDX_W'(FRAME_BYTES - 1)) begin
            frame_byte = frame_checksum(seq, w);
        end else begin
            frame_byte = off[0] ? ext[7:0] : ext[15:8];
        end
    endfunction

endpackage

// File: rtl/waveform_uart_framer_tx_byte_stage.sv
// rtl/waveform_uart_framer_tx_byte_stage.sv - output byte register with valid/ready handshake
module tx_byte_stage (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       clear,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       accept
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    assign accept   = valid_q & tx_ready;
    assign tx_data  = data_q;
    assign tx_valid = valid_q;

    // Hold the byte until the framer loads the next one or retires the frame.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/waveform_uart_framer.sv
// rtl/waveform_uart_framer.sv - trigger-driven snapshot of the capture array streamed as a framed byte sequence
module waveform_uart_framer
    import waveform_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger_in,
    input  waveform_t  waveform,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] dropped_count
);

    framer_state_t    state_q, state_d;
    logic             trig_q, trig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       seq_q, seq_d;
    logic             busy_q, busy_d;
    logic [7:0]       drop_q, drop_d;
    waveform_t        snap_q, snap_d;

    logic       rise;
    logic       load;
    logic [7:0] load_data;
    logic       clear;
    logic       accept;

    assign busy          = busy_q;
    assign dropped_count = drop_q;

    tx_byte_stage u_tx_stage (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .clear     (clear),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .accept    (accept)
    );

    // Frame sequencing: wait for the capture array to settle, snapshot, then walk the frame bytes.
    always_comb begin
        state_d   = state_q;
        trig_d    = trigger_in;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        busy_d    = busy_q;
        drop_d    = drop_q;
        snap_d    = snap_q;
        load      = 1'b0;
        load_data = SYNC_BYTE;
        clear     = 1'b0;
        rise      = trigger_in & ~trig_q;

        // Any rising edge outside IDLE, including the frame's final edge, is a dropped trigger.
        if (rise && state_q != IDLE && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = SETTLE;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    snap_d    = waveform;
                    state_d   = SEND;
                    idx_d     = '0;
                    load      = 1'b1;
                    load_data = SYNC_BYTE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
                        clear   = 1'b1;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        seq_d   = seq_q + 8'd1;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        load      = 1'b1;
                        load_data = frame_byte(idx_q + IDX_W'(1), seq_q, snap_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Framer state registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            seq_q   <= 8'd0;
            busy_q  <= 1'b0;
            drop_q  <= 8'd0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            snap_q  <= snap_d;
        end
    end

endmodule

// File: tb/tb_waveform_uart_framer.sv
// tb/tb_waveform_uart_framer.sv - self-checking bench for the waveform UART framer
module tb_waveform_uart_framer;
    import waveform_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       trigger_in;
    logic       tx_ready;
    logic       tx_valid;
    logic       busy;
    logic [7:0] tx_data;
    logic [7:0] dropped_count;
    waveform_t  wf_bus;
    sample_t    wf_cur [N_SAMPLES];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int exp_seq  = 0;
    int exp_drop = 0;

    int cyc, hold_cyc, pulse_start, pulse_per, pulse_max, pulses;
    int stall_err, extra_busy, lat, end_cyc;
    bit tmo, busy_e0, end_busy, end_valid, scramble_en;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_SAMPLES; g++) begin : g_wf
        assign wf_bus[g] = wf_cur[g];
    end

    waveform_uart_framer dut (
        .clk           (clk),
        .rst           (rst),
        .trigger_in    (trigger_in),
        .waveform      (wf_bus),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .dropped_count (dropped_count)
    );

    // Expected frame from the current array and the bench's own sequence counter.
    task automatic build_expected();
        int x;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(exp_seq));
        x = exp_seq;
        for (int i = 0; i < N_SAMPLES; i++) begin
            int v;
            v = int'(wf_cur[i]);
            exp_q.push_back(8'(v / 256));
            exp_q.push_back(8'(v % 256));
            x = x ^ (v / 256) ^ (v % 256);
        end
        exp_q.push_back(8'(x));
    endtask

    task automatic drive_trig();
        if (cyc < hold_cyc) begin
            trigger_in = 1'b1;
        end else if (!trigger_in && pulses < pulse_max && cyc >= pulse_start && (cyc % pulse_per) == 0) begin
            trigger_in = 1'b1;
            pulses++;
        end else begin
            trigger_in = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drive_trig();
    endtask

    task automatic run_frame(input int ready_pct, input int limit);
        int guard;
        logic pv, pr;
        logic [7:0] pd;
        got.delete();
        stall_err = 0; extra_busy = 0; tmo = 0; lat = -1; pulses = 0; end_cyc = -1;
        build_expected();
        @(negedge clk); trigger_in = 1'b0; tx_ready = 1'b1;
        @(negedge clk); trigger_in = 1'b1;
        @(posedge clk); cyc = 0;
        @(negedge clk); drive_trig();
        busy_e0 = busy;
        guard = 0;
        while (!tx_valid && guard < 100) begin
            step();
            guard++;
        end
        if (!tx_valid) begin
            tmo = 1;
            trigger_in = 1'b0;
            return;
        end
        lat = cyc;
        if (scramble_en) begin
            for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'($urandom);
        end
        pv = 1'b0; pr = 1'b0; pd = 8'd0; guard = 0;
        while (1) begin
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (!tx_valid) begin
                stall_err++;
                break;
            end
            if (pv && !pr && tx_data !== pd) stall_err++;
            if (tx_ready) got.push_back(tx_data);
            pv = 1'b1; pr = tx_ready; pd = tx_data;
            if (got.size() >= limit) break;
            if (guard >= 8000) begin
                tmo = 1;
                break;
            end
            step();
            guard++;
        end
        pulse_max = pulses;
        if (limit < FRAME_BYTES) return;
        step();
        end_cyc = cyc; end_busy = busy; end_valid = tx_valid; tx_ready = 1'b1;
        while (cyc <= hold_cyc + 2) begin
            step();
            if (busy || tx_valid) extra_busy++;
        end
        trigger_in = 1'b0;
        exp_seq  = (exp_seq + 1) % 256;
        exp_drop = (exp_drop + pulses > 255) ? 255 : exp_drop + pulses;
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger_in = 1'b0; tx_ready = 1'b0;
        hold_cyc = 1; pulse_start = 0; pulse_per = 2; pulse_max = 0; pulses = 0; cyc = 0; scramble_en = 0;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b need 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h need 00", tx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_cmp++; if (dropped_count !== 8'h00) begin n_bad++; $display("FAIL reset_dropped: got %h need 00", dropped_count); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ramp();
        int nm;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'(i);
        run_frame(100, FRAME_BYTES);
        n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL ramp_latency: got %0d need 33", lat); end
        n_cmp++; if (busy_e0 !== 1'b1) begin n_bad++; $display("FAIL ramp_busy_after_e0: got %b need 1", busy_e0); end
        nm = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
        n_cmp++; if (nm != 0 || got.size() != exp_q.size()) begin n_bad++; $display("FAIL ramp_bytes: %0d wrong, got %0d bytes need %0d", nm, got.size(), exp_q.size()); end
        n_cmp++; if (got.size() != FRAME_BYTES || got[FRAME_BYTES-1] !== 8'h00) begin n_bad++; $display("FAIL ramp_checksum: got size %0d need checksum 00", got.size()); end
        n_cmp++; if (end_cyc !== 100) begin n_bad++; $display("FAIL ramp_throughput: got end cycle %0d need 100", end_cyc); end
        n_cmp++; if (end_busy !== 1'b0 || end_valid !== 1'b0) begin n_bad++; $display("FAIL ramp_end: got busy %b valid %b need 0 0", end_busy, end_valid); end
    endtask

    task automatic test_checksum_seq();
        int nm;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = 14'h3ABC;
        run_frame(100, FRAME_BYTES);
        nm = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
        n_cmp++; if (nm != 0 || got.size() != exp_q.size()) begin n_bad++; $display("FAIL csum_bytes: %0d wrong, got %0d bytes need %0d", nm, got.size(), exp_q.size()); end
        n_cmp++; if (got.size() != FRAME_BYTES || got[1] !== 8'h01 || got[2] !== 8'h3A || got[3] !== 8'hBC || got[FRAME_BYTES-1] !== 8'h01) begin
            n_bad++; $display("FAIL csum_fields: got size %0d need seq 01 hi 3A lo BC csum 01", got.size());
        end
    endtask

    task automatic test_backpressure();
        int nm;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'($urandom);
        scramble_en = 1;
        run_frame(50, FRAME_BYTES);
        scramble_en = 0;
        nm = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
        n_cmp++; if (nm != 0 || got.size() != exp_q.size() || tmo) begin n_bad++; $display("FAIL bp_bytes: %0d wrong, got %0d bytes need %0d, timeout %b", nm, got.size(), exp_q.size(), tmo); end
        n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d stall violations need 0", stall_err); end
        n_cmp++; if (end_busy !== 1'b0) begin n_bad++; $display("FAIL bp_end_busy: got %b need 0", end_busy); end
    endtask

    task automatic test_busy_triggers();
        int nm;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'($urandom);
        pulse_start = 40; pulse_per = 4; pulse_max = 3;
        run_frame(100, FRAME_BYTES);
        nm = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
        n_cmp++; if (nm != 0 || got.size() != exp_q.size()) begin n_bad++; $display("FAIL busy_trig_bytes: %0d wrong, got %0d bytes need %0d", nm, got.size(), exp_q.size()); end
        n_cmp++; if (dropped_count !== 8'd3) begin n_bad++; $display("FAIL busy_trig_dropped: got %0d need 3", dropped_count); end
        pulse_max = 0;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'($urandom);
        run_frame(100, FRAME_BYTES);
        nm = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
        n_cmp++; if (nm != 0 || got.size() != exp_q.size()) begin n_bad++; $display("FAIL busy_next_frame: %0d wrong, got %0d bytes need %0d", nm, got.size(), exp_q.size()); end
        n_cmp++; if (dropped_count !== 8'(exp_drop)) begin n_bad++; $display("FAIL busy_next_dropped: got %0d need %0d", dropped_count, exp_drop); end
    endtask

    task automatic test_reset_midframe();
        int nm;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'($urandom);
        run_frame(100, 11);
        n_cmp++; if (got.size() != 11) begin n_bad++; $display("FAIL rstmid_prefix: got %0d bytes need 11", got.size()); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_immediate: got valid %b busy %b need 0 0", tx_valid, busy); end
        @(negedge clk);
        rst = 1'b0; trigger_in = 1'b0;
        exp_seq = 0; exp_drop = 0;
        @(negedge clk);
        n_cmp++; if (dropped_count !== 8'h00) begin n_bad++; $display("FAIL rstmid_dropped: got %h need 00", dropped_count); end
        run_frame(100, FRAME_BYTES);
        nm = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
        n_cmp++; if (nm != 0 || got.size() != exp_q.size() || got[1] !== 8'h00) begin n_bad++; $display("FAIL rstmid_next_frame: %0d wrong, got %0d bytes need %0d with seq 00", nm, got.size(), exp_q.size()); end
    endtask

    task automatic test_held_trigger();
        int nm;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'($urandom);
        hold_cyc = 200;
        run_frame(100, FRAME_BYTES);
        hold_cyc = 1;
        nm = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
        n_cmp++; if (nm != 0 || got.size() != exp_q.size()) begin n_bad++; $display("FAIL held_bytes: %0d wrong, got %0d bytes need %0d", nm, got.size(), exp_q.size()); end
        n_cmp++; if (extra_busy !== 0) begin n_bad++; $display("FAIL held_single_frame: got %0d busy cycles after frame need 0", extra_busy); end
        n_cmp++; if (dropped_count !== 8'(exp_drop)) begin n_bad++; $display("FAIL held_dropped: got %0d need %0d", dropped_count, exp_drop); end
    endtask

    task automatic test_seq_wrap();
        int bad_frames;
        bit saw_wrap;
        logic [7:0] prev_seq;
        bad_frames = 0; saw_wrap = 0; prev_seq = 8'h00;
        for (int f = 0; f < 256; f++) begin
            int nm;
            for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'($urandom);
            run_frame(100, FRAME_BYTES);
            nm = 0;
            foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
            if (nm != 0 || got.size() != exp_q.size() || tmo) bad_frames++;
            if (got.size() > 1) begin
                if (f > 0 && prev_seq == 8'hFF && got[1] == 8'h00) saw_wrap = 1;
                prev_seq = got[1];
            end
        end
        n_cmp++; if (bad_frames !== 0) begin n_bad++; $display("FAIL wrap_frames: got %0d bad frames need 0", bad_frames); end
        n_cmp++; if (saw_wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_seq: got no FF->00 transition, need one"); end
    endtask

    task automatic test_drop_saturate();
        int nm;
        for (int i = 0; i < N_SAMPLES; i++) wf_cur[i] = sample_t'($urandom);
        pulse_start = 2; pulse_per = 2; pulse_max = 300;
        run_frame(5, FRAME_BYTES);
        pulse_max = 0;
        nm = 0;
        foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) nm++;
        n_cmp++; if (nm != 0 || got.size() != exp_q.size() || tmo) begin n_bad++; $display("FAIL sat_bytes: %0d wrong, got %0d bytes need %0d", nm, got.size(), exp_q.size()); end
        n_cmp++; if (dropped_count !== 8'(exp_drop)) begin n_bad++; $display("FAIL sat_dropped_model: got %0d need %0d (pulses %0d)", dropped_count, exp_drop, pulses); end
        n_cmp++; if (pulses >= 255 && dropped_count !== 8'hFF) begin n_bad++; $display("FAIL sat_dropped_ff: got %h need FF", dropped_count); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_checksum_seq();
        test_backpressure();
        test_busy_triggers();
        test_reset_midframe();
        test_held_trigger();
        test_seq_wrap();
        test_drop_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
